// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide for the execute stage.
//   Multiply: MSB-first shift-add over operand magnitudes into a 2*XLEN accumulator.
//   Divide:   restoring division over magnitudes, one quotient bit per cycle.
//   Both take XLEN CALC cycles. Divide-by-zero and signed overflow skip CALC entirely.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, funct3       M-op request and selector (MUL..REMU)
//   op1, op2, rd_addr   rs1/rs2 data and destination register from decode
//   flush               abort an in-flight op (branch/jump taken)
//   busy                stall request to PC/decode
//   done                one-cycle result-valid pulse
//   result, rd_addr_o   write-back data and register, held until the next done
//   rd_wen_o            register file write enable (mirrors done)
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010;
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;

  logic [2:0]        f3;
  logic [4:0]        rd_q;
  logic              neg;     // negate the final product / quotient / remainder
  logic [XLEN-1:0]   a, b;    // a: multiplicand magnitude, b: multiplier or divisor magnitude
  logic [2*XLEN-1:0] acc;     // product, or {remainder, dividend->quotient}
  logic [CW-1:0]     cnt;

  // Operand conditioning at accept time
  logic            in_div, s1, s2, in_neg, fast;
  logic [XLEN-1:0] mag1, mag2, fast_res;

  always_comb begin
    in_div = funct3[2];
    if (in_div) begin
      s1 = ~funct3[0] & op1[XLEN-1];
      s2 = ~funct3[0] & op2[XLEN-1];
    end else begin
      s1 = ((funct3 == F_MULH) || (funct3 == F_MULHSU)) & op1[XLEN-1];
      s2 = (funct3 == F_MULH) & op2[XLEN-1];
    end
    // Remainder follows the dividend; everything else follows the sign XOR.
    in_neg = (in_div && funct3[1]) ? s1 : (s1 ^ s2);
    mag1 = s1 ? -op1 : op1;
    mag2 = s2 ? -op2 : op2;

    fast     = 1'b0;
    fast_res = '0;
    if (in_div && (op2 == '0)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? op1 : ONES;
    end else if (in_div && !funct3[0] && (op1 == SMIN) && (op2 == ONES)) begin
      fast     = 1'b1;
      fast_res = funct3[1] ? '0 : SMIN;
    end
  end

  // One iteration of the active algorithm, plus the result it would produce
  // if this is the last iteration.
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   fin, qr;

  always_comb begin
    diff = acc[2*XLEN-1:XLEN-1] - {1'b0, b};
    if (f3[2]) begin
      // Restoring step: keep the subtraction only when it did not borrow.
      if (!diff[XLEN]) step_acc = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             step_acc = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      step_acc = {acc[2*XLEN-2:0], 1'b0} + (b[XLEN-1] ? {{XLEN{1'b0}}, a} : '0);
    end

    prod = neg ? -step_acc : step_acc;
    qr   = f3[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
    if (f3[2])             fin = neg ? -qr : qr;
    else if (f3 == F_MUL)  fin = prod[XLEN-1:0];
    else                   fin = prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_wen_o  <= 1'b0;
      result    <= '0;
      rd_addr_o <= '0;
      f3        <= '0;
      rd_q      <= '0;
      neg       <= 1'b0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      done     <= 1'b0;
      rd_wen_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            f3   <= funct3;
            rd_q <= rd_addr;
            neg  <= in_neg;
            a    <= mag1;
            b    <= mag2;
            acc  <= in_div ? {{XLEN{1'b0}}, mag1} : '0;
            cnt  <= '0;
            if (fast) begin
              state     <= DONE;
              done      <= 1'b1;
              rd_wen_o  <= 1'b1;
              result    <= fast_res;
              rd_addr_o <= rd_addr;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= step_acc;
            if (!f3[2]) b <= {b[XLEN-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN-1)) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              rd_wen_o  <= 1'b1;
              result    <= fin;
              rd_addr_o <= rd_q;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic [4:0]  rd_addr;
  logic        busy, done, rd_wen_o;
  logic [31:0] result;
  logic [4:0]  rd_addr_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op1(op1), .op2(op2), .rd_addr(rd_addr), .flush(flush),
    .busy(busy), .done(done), .result(result),
    .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op in one cycle; returns just after the accepting edge T.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f; op1 = a; op2 = b; rd_addr = rd;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full op with latency and output checks.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit fast_path);
    start_op(f, a, b, rd);
    if (!fast_path) begin
      @(negedge clk);                        // cycle T+1
      chk({tag, " busy@T+1"}, 32'(busy), 32'd1);
      chk({tag, " done@T+1"}, 32'(done), 32'd0);
      repeat (31) @(negedge clk);            // cycle T+32
      chk({tag, " busy@T+32"}, 32'(busy), 32'd1);
      chk({tag, " done@T+32"}, 32'(done), 32'd0);
    end
    @(negedge clk);                          // DONE cycle
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " wen"}, 32'(rd_wen_o), 32'd1);
    chk({tag, " busy@done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, result, exp);
    chk({tag, " rd"}, 32'(rd_addr_o), 32'(rd));
    @(negedge clk);
    chk({tag, " done drop"}, 32'(done), 32'd0);
    chk({tag, " result hold"}, result, exp);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op1 = '0; op2 = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst wen", 32'(rd_wen_o), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst rd", 32'(rd_addr_o), 32'd0);
    rst_n = 1'b1;

    // Multiply
    run_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0);
    run_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 0);
    run_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 0);
    run_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 0);
    // Divide
    run_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 0);
    run_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 0);
    run_op("DIVU",   3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       0);
    run_op("REMU",   3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        0);

    // Flush at T+10: busy drops at T+11, no done, result keeps 2
    start_op(3'b101, 32'd100, 32'd7, 5'd14);
    @(negedge clk);                          // T+1
    repeat (9) @(negedge clk);               // T+10
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);                          // T+11
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush result", result, 32'd2);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || rd_wen_o) pulses++;
    end
    chk("flush no done", 32'(pulses), 32'd0);
    chk("flush busy idle", 32'(busy), 32'd0);

    // Fast paths
    run_op("DIVU/0",  3'b101, 32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 1);
    run_op("REM/0",   3'b110, 32'd5,        32'd0,        5'd16, 32'd5,        1);
    run_op("DIV ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1);
    run_op("REM ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        1);

    // Start during CALC with different operands is ignored
    start_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd3);
    @(negedge clk);                          // T+1
    repeat (2) @(negedge clk);               // T+3
    start = 1'b1; funct3 = 3'b101; op1 = 32'd100; op2 = 32'd7; rd_addr = 5'd20;
    repeat (2) @(negedge clk);               // T+5
    start = 1'b0;
    repeat (27) @(negedge clk);              // T+32
    chk("ign busy@T+32", 32'(busy), 32'd1);
    @(negedge clk);                          // T+33
    chk("ign done", 32'(done), 32'd1);
    chk("ign result", result, 32'hFFFFFFEB);
    chk("ign rd", 32'(rd_addr_o), 32'd3);
    run_op("DIVU after", 3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 0);

    // Reset mid-operation at T+5
    start_op(3'b011, 32'd9, 32'd9, 5'd22);
    @(negedge clk);                          // T+1
    repeat (4) @(negedge clk);               // T+5
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst done", 32'(done), 32'd0);
    chk("mrst result", result, 32'd0);
    chk("mrst rd", 32'(rd_addr_o), 32'd0);
    chk("mrst wen", 32'(rd_wen_o), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("mrst no done", 32'(pulses), 32'd0);

    // Write to x0 still asserts the write enable
    run_op("MUL x0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
